mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle main controller for the MIPS32 core; sequences PC, IR, GRF, ALU, DM and npc.
//  Decodes opcode/funct from the IR and walks a 5-state FSM.
//  Drives npc_slc and pc_we so the PC register is written exactly once per instruction,
//  in that instruction's final cycle. This keeps npc's pc_in equal to the current
//  instruction's address for beq/j/jal.
// PARAMETERS
//  MEM_WAIT  0  extra cycles held in MEM state for DM latency (0..15)
//  CNT_W     4  width of MEM wait counter; must hold MEM_WAIT
// PORTS
//  clk      in   1  clock, all state updates on rising edge
//  reset    in   1  synchronous, active-high reset
//  opcode   in   6  IR[31:26]
//  funct    in   6  IR[5:0]
//  pc_we    out  1  PC register write enable
//  npc_slc  out  3  000 pc+4, 001 beq, 010 j, 011 jal, 100 jr
//  ir_we    out  1  IR write enable
//  reg_we   out  1  GRF write enable
//  regdst   out  2  00 rt, 01 rd, 10 $31
//  alusrc   out  1  0 GRF rt, 1 extended imm
//  alu_op   out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
//  ext_op   out  1  0 zero-extend, 1 sign-extend
//  mem_we   out  1  DM write enable
//  wd_sel   out  2  GRF write data: 00 ALU, 01 DM, 10 pc_4
//  state    out  3  current FSM state (debug)
// BEHAVIOUR
//  - Supported instructions: addu (op 0, fn 21h), subu (0/23h), jr (0/08h), ori (0Dh), lw (23h),
//    sw (2Bh), beq (04h), lui (0Fh), j (02h), jal (03h).
//    Any other op/funct is a nop.
//  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH next
//    cycle with all strobes 0.
//  - Outputs are combinational from state plus decode. All strobes not listed below are 0.
//    Non-strobe outputs default to 0 unless the instruction defines them.
//  - FETCH: ir_we=1 -> DECODE. The opcode/funct inputs are ignored in FETCH.
//  - DECODE:
//    - j: pc_we=1, npc_slc=010 -> FETCH.
//    - jal: reg_we=1, regdst=10, wd_sel=10, pc_we=1, npc_slc=011 -> FETCH.
//    - jr: pc_we=1, npc_slc=100 -> FETCH.
//    - nop/illegal: pc_we=1, npc_slc=000 -> FETCH.
//    - all others -> EXEC.
//  - EXEC:
//    - beq: alu_op=001, alusrc=0, ext_op=1, pc_we=1, npc_slc=001 -> FETCH.
//      npc resolves taken/not-taken itself from alu_zero.
//    - lw/sw: alu_op=000, alusrc=1, ext_op=1 -> MEM.
//    - addu/subu/ori/lui -> WB.
//  - MEM:
//    - Wait counter loads 0 on entry and increments each MEM cycle.
//      MEM lasts MEM_WAIT+1 cycles.
//    - Address controls (alu_op=000, alusrc=1, ext_op=1) are held the whole time.
//    - sw: mem_we=1 in the first MEM cycle only. In the last MEM cycle pc_we=1,
//      npc_slc=000 -> FETCH.
//    - lw: last MEM cycle -> WB.
//  - WB: reg_we=1, pc_we=1, npc_slc=000 -> FETCH. Per-instruction controls:
//    - addu: regdst=01, alusrc=0, alu_op=000, wd_sel=00.
//    - subu: regdst=01, alusrc=0, alu_op=001, wd_sel=00.
//    - ori: regdst=00, alusrc=1, ext_op=0, alu_op=010, wd_sel=00.
//    - lui: regdst=00, alusrc=1, alu_op=011, wd_sel=00.
//    - lw: regdst=00, wd_sel=01; ALU controls as in MEM.
//  - EXEC/WB hold ALU controls identical to each other, so operands stay stable.
//  - Cycles per instruction: j/jal/jr/nop 2; beq 3; addu/subu/ori/lui 4;
//    sw 4+MEM_WAIT; lw 5+MEM_WAIT.
//  - Reset, including mid-instruction:
//    - Next cycle: state=FETCH, counter=0.
//    - While reset=1, pc_we, ir_we, reg_we and mem_we are forced to 0 whatever the state.
//    - A partially executed instruction is abandoned, with no write.
//  - pc_we is asserted exactly once per instruction and never together with ir_we.
// TESTING
//  - Reset, then addu (op 00, fn 21h): states 0,1,2,4. reg_we=1, regdst=01, pc_we=1 and
//    npc_slc=000 only in cycle 4.
//  - lw with MEM_WAIT=2: states 0,1,2,3,3,3,4 (7 cycles). mem_we never 1. WB shows wd_sel=01,
//    regdst=00.
//  - sw with MEM_WAIT=0: 4 cycles. mem_we=1 and pc_we=1 in the same single MEM cycle.
//  - beq with alu_zero held 0, then repeated with alu_zero held 1: both cases show
//    pc_we=1, npc_slc=001, alu_op=001 in cycle 3.
//  - jal: cycle 2 shows reg_we=1, regdst=10, wd_sel=10, npc_slc=011.
//    jr (fn 08h): cycle 2 shows npc_slc=100.
//  - reset=1 during WB of ori: reg_we=0 and pc_we=0 in that cycle, then FETCH.
//    Illegal op 3Fh: 2-cycle nop with pc_we=1 in DECODE.

Source files
------------

// File: rtl/mc_ctrl.sv
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle MIPS32 main controller (FETCH/DECODE/EXEC/MEM/WB).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       pc_we,
    output logic [2:0] npc_slc,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] regdst,
    output logic       alusrc,
    output logic [2:0] alu_op,
    output logic       ext_op,
    output logic       mem_we,
    output logic [1:0] wd_sel,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUBU    = 6'h23;
    localparam logic [5:0] c_FN_JR      = 6'h08;

    localparam logic [2:0] c_NPC_PC4  = 3'b000;
    localparam logic [2:0] c_NPC_BEQ  = 3'b001;
    localparam logic [2:0] c_NPC_J    = 3'b010;
    localparam logic [2:0] c_NPC_JAL  = 3'b011;
    localparam logic [2:0] c_NPC_JR   = 3'b100;

    localparam logic [CNT_W-1:0] c_MEM_LAST = CNT_W'(MEM_WAIT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_exec_class, w_mem_last;
    logic       w_alusrc;
    logic [2:0] w_alu_op;
    logic       w_ext_op;

    assign w_addu = (opcode == c_OP_SPECIAL) && (funct == c_FN_ADDU);
    assign w_subu = (opcode == c_OP_SPECIAL) && (funct == c_FN_SUBU);
    assign w_jr   = (opcode == c_OP_SPECIAL) && (funct == c_FN_JR);
    assign w_ori  = (opcode == c_OP_ORI);
    assign w_lw   = (opcode == c_OP_LW);
    assign w_sw   = (opcode == c_OP_SW);
    assign w_beq  = (opcode == c_OP_BEQ);
    assign w_lui  = (opcode == c_OP_LUI);
    assign w_j    = (opcode == c_OP_J);
    assign w_jal  = (opcode == c_OP_JAL);

    assign w_exec_class = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq;
    assign w_mem_last   = (r_cnt == c_MEM_LAST);
    assign state        = r_state;

    // One ALU control set per instruction, reused in EXEC, MEM and WB so
    // operands stay stable across the whole datapath walk.
    always_comb begin
        w_alusrc = 1'b0;
        w_alu_op = 3'b000;
        w_ext_op = 1'b0;
        if (w_subu) begin
            w_alu_op = 3'b001;
        end else if (w_ori) begin
            w_alusrc = 1'b1;
            w_alu_op = 3'b010;
        end else if (w_lui) begin
            w_alusrc = 1'b1;
            w_alu_op = 3'b011;
        end else if (w_lw || w_sw) begin
            w_alusrc = 1'b1;
            w_ext_op = 1'b1;
        end else if (w_beq) begin
            w_alu_op = 3'b001;
            w_ext_op = 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        pc_we   = 1'b0;
        npc_slc = c_NPC_PC4;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        regdst  = 2'b00;
        alusrc  = 1'b0;
        alu_op  = 3'b000;
        ext_op  = 1'b0;
        mem_we  = 1'b0;
        wd_sel  = 2'b00;
        case (r_state)
            S_FETCH: begin
                ir_we  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_exec_class) begin
                    w_next = S_EXEC;
                end else begin
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                    if (w_j) begin
                        npc_slc = c_NPC_J;
                    end else if (w_jal) begin
                        npc_slc = c_NPC_JAL;
                        reg_we  = 1'b1;
                        regdst  = 2'b10;
                        wd_sel  = 2'b10;
                    end else if (w_jr) begin
                        npc_slc = c_NPC_JR;
                    end
                end
            end
            S_EXEC: begin
                alusrc = w_alusrc;
                alu_op = w_alu_op;
                ext_op = w_ext_op;
                if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_addu || w_subu || w_ori || w_lui) begin
                    w_next = S_WB;
                end else begin
                    // beq resolves here; anything else can only arrive via a
                    // corrupted IR and is retired as pc+4.
                    pc_we   = 1'b1;
                    npc_slc = w_beq ? c_NPC_BEQ : c_NPC_PC4;
                    w_next  = S_FETCH;
                end
            end
            S_MEM: begin
                alusrc = w_alusrc;
                alu_op = w_alu_op;
                ext_op = w_ext_op;
                mem_we = w_sw && (r_cnt == '0);
                if (w_mem_last) begin
                    if (w_sw) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                alusrc = w_alusrc;
                alu_op = w_alu_op;
                ext_op = w_ext_op;
                reg_we = 1'b1;
                pc_we  = 1'b1;
                regdst = (w_addu || w_subu) ? 2'b01 : 2'b00;
                wd_sel = w_lw ? 2'b01 : 2'b00;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            reg_we = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_MEM && w_next == S_MEM) ? r_cnt + 1'b1 : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl (MEM_WAIT=0 and MEM_WAIT=2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic [2:0] npc_slc;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] regdst;
        logic       alusrc;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       mem_we;
        logic [1:0] wd_sel;
    } rec_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       sel;
        int         len;
        rec_t       last;
    } vec_t;

    localparam int I_ADDU = 0, I_SUBU = 1, I_JR = 2, I_ORI = 3, I_LW = 4, I_SW = 5;
    localparam int I_BEQ = 6, I_LUI = 7, I_J = 8, I_JAL = 9, I_NOP = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       sel;

    logic       pw_a, iw_a, rw_a, as_a, eo_a, mw_a;
    logic [2:0] ns_a, ao_a, st_a;
    logic [1:0] rd_a, ws_a;
    logic       pw_b, iw_b, rw_b, as_b, eo_b, mw_b;
    logic [2:0] ns_b, ao_b, st_b;
    logic [1:0] rd_b, ws_b;

    rec_t act_a, act_b, act;
    rec_t sched[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .pc_we(pw_a), .npc_slc(ns_a), .ir_we(iw_a), .reg_we(rw_a), .regdst(rd_a),
        .alusrc(as_a), .alu_op(ao_a), .ext_op(eo_a), .mem_we(mw_a), .wd_sel(ws_a),
        .state(st_a)
    );

    mc_ctrl #(.MEM_WAIT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .pc_we(pw_b), .npc_slc(ns_b), .ir_we(iw_b), .reg_we(rw_b), .regdst(rd_b),
        .alusrc(as_b), .alu_op(ao_b), .ext_op(eo_b), .mem_we(mw_b), .wd_sel(ws_b),
        .state(st_b)
    );

    assign act_a = {st_a, pw_a, ns_a, iw_a, rw_a, rd_a, as_a, ao_a, eo_a, mw_a, ws_a};
    assign act_b = {st_b, pw_b, ns_b, iw_b, rw_b, rd_b, as_b, ao_b, eo_b, mw_b, ws_b};
    assign act   = sel ? act_b : act_a;

    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h21) ? I_ADDU : (fn == 6'h23) ? I_SUBU :
                            (fn == 6'h08) ? I_JR : I_NOP;
            6'h0D:   return I_ORI;
            6'h23:   return I_LW;
            6'h2B:   return I_SW;
            6'h04:   return I_BEQ;
            6'h0F:   return I_LUI;
            6'h02:   return I_J;
            6'h03:   return I_JAL;
            default: return I_NOP;
        endcase
    endfunction

    // ALU controls an instruction keeps from EXEC through WB.
    function automatic rec_t with_alu(rec_t r, int cls);
        rec_t o = r;
        case (cls)
            I_SUBU: o.alu_op = 3'd1;
            I_ORI:  begin o.alusrc = 1'b1; o.alu_op = 3'd2; end
            I_LUI:  begin o.alusrc = 1'b1; o.alu_op = 3'd3; end
            I_LW, I_SW: begin o.alusrc = 1'b1; o.ext_op = 1'b1; end
            I_BEQ:  begin o.alu_op = 3'd1; o.ext_op = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // Expected cycle-by-cycle output trace of one instruction.
    task automatic build(int cls, int mw);
        rec_t r;
        sched.delete();
        r = '0; r.state = 3'd0; r.ir_we = 1'b1;
        sched.push_back(r);
        r = '0; r.state = 3'd1;
        case (cls)
            I_J:   begin r.pc_we = 1'b1; r.npc_slc = 3'd2; end
            I_JAL: begin r.pc_we = 1'b1; r.npc_slc = 3'd3; r.reg_we = 1'b1;
                         r.regdst = 2'd2; r.wd_sel = 2'd2; end
            I_JR:  begin r.pc_we = 1'b1; r.npc_slc = 3'd4; end
            I_NOP: r.pc_we = 1'b1;
            default: ;
        endcase
        sched.push_back(r);
        if (cls == I_J || cls == I_JAL || cls == I_JR || cls == I_NOP) return;
        r = '0; r.state = 3'd2; r = with_alu(r, cls);
        if (cls == I_BEQ) begin r.pc_we = 1'b1; r.npc_slc = 3'd1; end
        sched.push_back(r);
        if (cls == I_BEQ) return;
        if (cls == I_LW || cls == I_SW) begin
            for (int k = 0; k <= mw; k++) begin
                r = '0; r.state = 3'd3; r = with_alu(r, cls);
                r.mem_we = (cls == I_SW) && (k == 0);
                r.pc_we  = (cls == I_SW) && (k == mw);
                sched.push_back(r);
            end
            if (cls == I_SW) return;
        end
        r = '0; r.state = 3'd4; r = with_alu(r, cls);
        r.reg_we = 1'b1; r.pc_we = 1'b1;
        r.regdst = (cls == I_ADDU || cls == I_SUBU) ? 2'd1 : 2'd0;
        r.wd_sel = (cls == I_LW) ? 2'd1 : 2'd0;
        sched.push_back(r);
    endtask

    task automatic check(string name, rec_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Entry/exit point: 1 time unit after a rising edge, DUT in FETCH.
    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int rst_at);
        rec_t exp;
        int   mw = sel ? 2 : 0;
        build(classify(op, fn), mw);
        for (int i = 0; i < sched.size(); i++) begin
            opcode = (i == 0) ? 6'($urandom) : op;
            funct  = (i == 0) ? 6'($urandom) : fn;
            reset  = (i == rst_at);
            @(negedge clk);
            exp = sched[i];
            if (i == rst_at) begin
                exp.pc_we = 1'b0; exp.ir_we = 1'b0; exp.reg_we = 1'b0; exp.mem_we = 1'b0;
            end
            check(name, exp);
            @(posedge clk); #1;
            if (i == rst_at) break;
        end
        reset = 1'b0;
    endtask

    task automatic run_directed(logic [5:0] op, logic [5:0] fn, output int len, output rec_t last);
        len  = 0;
        last = '0;
        for (int i = 1; i <= 40; i++) begin
            opcode = (i == 1) ? 6'($urandom) : op;
            funct  = (i == 1) ? 6'($urandom) : fn;
            @(negedge clk);
            if (act.pc_we === 1'b1) begin
                len  = i;
                last = act;
            end
            @(posedge clk); #1;
            if (len != 0) break;
        end
    endtask

    function automatic rec_t mk(int st, int pw, int ns, int rw, int rd, int as,
                                int ao, int eo, int mw, int ws);
        rec_t r = '0;
        r.state = 3'(st); r.pc_we = 1'(pw); r.npc_slc = 3'(ns); r.reg_we = 1'(rw);
        r.regdst = 2'(rd); r.alusrc = 1'(as); r.alu_op = 3'(ao); r.ext_op = 1'(eo);
        r.mem_we = 1'(mw); r.wd_sel = 2'(ws);
        return r;
    endfunction

    vec_t tbl[13];
    logic [5:0] leg_op[10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03};
    logic [5:0] leg_fn[10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        int   len;
        rec_t last;
        rec_t z;

        //            name       op     fn     sel  len  last-cycle outputs
        tbl[0]  = '{"addu",   6'h00, 6'h21, 1'b0, 4, mk(4, 1, 0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{"subu",   6'h00, 6'h23, 1'b0, 4, mk(4, 1, 0, 1, 1, 0, 1, 0, 0, 0)};
        tbl[2]  = '{"ori",    6'h0D, 6'h15, 1'b0, 4, mk(4, 1, 0, 1, 0, 1, 2, 0, 0, 0)};
        tbl[3]  = '{"lui",    6'h0F, 6'h3C, 1'b0, 4, mk(4, 1, 0, 1, 0, 1, 3, 0, 0, 0)};
        tbl[4]  = '{"lw_w2",  6'h23, 6'h04, 1'b1, 7, mk(4, 1, 0, 1, 0, 1, 0, 1, 0, 1)};
        tbl[5]  = '{"lw_w0",  6'h23, 6'h04, 1'b0, 5, mk(4, 1, 0, 1, 0, 1, 0, 1, 0, 1)};
        tbl[6]  = '{"sw_w0",  6'h2B, 6'h08, 1'b0, 4, mk(3, 1, 0, 0, 0, 1, 0, 1, 1, 0)};
        tbl[7]  = '{"sw_w2",  6'h2B, 6'h08, 1'b1, 6, mk(3, 1, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[8]  = '{"beq",    6'h04, 6'h21, 1'b1, 3, mk(2, 1, 1, 0, 0, 0, 1, 1, 0, 0)};
        tbl[9]  = '{"j",      6'h02, 6'h21, 1'b1, 2, mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{"jal",    6'h03, 6'h00, 1'b1, 2, mk(1, 1, 3, 1, 2, 0, 0, 0, 0, 2)};
        tbl[11] = '{"jr",     6'h00, 6'h08, 1'b1, 2, mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{"illegal",6'h3F, 6'h21, 1'b1, 2, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};

        sel    = 1'b0;
        reset  = 1'b1;
        opcode = 6'h2B;
        funct  = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        z = '0;
        check("reset_state", z);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (sel != tbl[i].sel) begin
                sel = tbl[i].sel;
                do_reset();
            end
            run_directed(tbl[i].op, tbl[i].fn, len, last);
            check_int({tbl[i].name, "_cycles"}, len, tbl[i].len);
            n_vec++;
            if (last !== tbl[i].last) begin
                n_err++;
                $display("FAIL %s_last: got %h expected %h", tbl[i].name, last, tbl[i].last);
            end
        end

        // Cycle-accurate sequences against the trace model.
        sel = 1'b0;
        do_reset();
        run_instr("seq_addu", 6'h00, 6'h21, -1);
        run_instr("seq_sw_w0", 6'h2B, 6'h11, -1);
        run_instr("seq_ori_rst_wb", 6'h0D, 6'h00, 3);
        run_instr("seq_after_rst", 6'h00, 6'h23, -1);
        run_instr("seq_lw_rst_mem", 6'h23, 6'h00, 3);
        sel = 1'b1;
        do_reset();
        run_instr("seq_lw_w2", 6'h23, 6'h00, -1);
        run_instr("seq_beq_a", 6'h04, 6'h00, -1);
        run_instr("seq_beq_b", 6'h04, 6'h00, -1);
        run_instr("seq_jal", 6'h03, 6'h00, -1);
        run_instr("seq_jr", 6'h00, 6'h08, -1);
        run_instr("seq_ill", 6'h3F, 6'h3F, -1);
        run_instr("seq_sw_rst_mem", 6'h2B, 6'h00, 4);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            repeat (150) begin
                int         idx = $urandom_range(0, 11);
                logic [5:0] op  = (idx < 10) ? leg_op[idx] : 6'($urandom);
                logic [5:0] fn  = (idx < 10) ? leg_fn[idx] : 6'($urandom);
                int         ra  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
                if (idx < 10 && op != 6'h00) fn = 6'($urandom);
                run_instr("rand", op, fn, ra);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
